// File: rtl/mdio_pkg.sv
// mdio_pkg: shared state encodings, opcodes and header field positions for the MDIO slave
package mdio_pkg;
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_HDR  = 5'b00010,
    S_WR   = 5'b00100,
    S_RD   = 5'b01000,
    S_DISC = 5'b10000
  } state_t;
  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [4:0] BIT_ST = 5'd1;
  localparam logic [4:0] BIT_HDR = 5'd15;
  localparam logic [4:0] BIT_DATA = 5'd16;
  localparam logic [4:0] BIT_LAST = 5'd31;
  localparam int OP_LSB = 12;
  localparam int PHYAD_LSB = 7;
  localparam int REGAD_LSB = 2;
endpackage

// File: rtl/mdio_edge_det.sv
// mdio_edge_det: registers mdc and flags its rising and falling edges in the clk domain
module mdio_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);
  logic mdc_q;
  always_ff @(posedge clk) mdc_q <= reset ? 1'b0 : mdc;
  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;
endmodule

// File: rtl/receptor_mdio.sv
// receptor_mdio: Clause-22 MDIO slave bridging frames to a register port; MDIO_PHYAD_CHECK_EN enables PHYAD filtering
module receptor_mdio
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  output logic        frame_err
);
  state_t state, state_n;
  logic rise, fall, ld, phy_ok, wr_n, rd_n, err_n, unused_bits;
  logic [4:0] bit_cnt, cnt_n, addr_n;
  logic [31:0] hdr_sr, sr_n, sh;
  logic [15:0] out_sr, osr_n, wd_n;
  mdio_edge_det u_edge (.clk(clk), .reset(reset), .mdc(mdc), .rise(rise), .fall(fall));
  assign sh = {hdr_sr[30:0], mdio_out};
  assign mdio_in = out_sr[15];
`ifdef MDIO_PHYAD_CHECK_EN
  assign phy_ok = sh[PHYAD_LSB +: 5] == PHY_ADDR;
  assign unused_bits = fall ^ hdr_sr[31];
`else
  assign phy_ok = 1'b1;
  assign unused_bits = ^{fall, hdr_sr[31], PHY_ADDR};
`endif
  always_comb begin
    state_n = state;
    cnt_n = bit_cnt;
    sr_n = hdr_sr;
    wd_n = wr_data;
    osr_n = ld ? rd_data : out_sr;
    addr_n = addr;
    wr_n = 1'b0;
    rd_n = 1'b0;
    err_n = 1'b0;
    unique case (state)
      S_IDLE: if (rise) begin
        osr_n = '0;
        if (mdio_oe) begin
          sr_n = {31'b0, mdio_out};
          cnt_n = 5'd1;
          state_n = S_HDR;
        end
      end
      S_HDR: if (rise) begin
        if (!mdio_oe) begin
          err_n = 1'b1;
          cnt_n = '0;
          state_n = S_IDLE;
        end else begin
          sr_n = sh;
          cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == BIT_ST && sh[1:0] != ST_CODE) begin
            err_n = 1'b1;
            cnt_n = '0;
            state_n = S_DISC;
          end else if (bit_cnt == BIT_HDR) begin
            addr_n = sh[REGAD_LSB +: 5];
            if (!phy_ok) begin
              cnt_n = '0;
              state_n = S_DISC;
            end else if (sh[OP_LSB +: 2] == OP_WR) state_n = S_WR;
            else if (sh[OP_LSB +: 2] == OP_RD) begin
              rd_n = 1'b1;
              state_n = S_RD;
            end else begin
              err_n = 1'b1;
              cnt_n = '0;
              state_n = S_DISC;
            end
          end
        end
      end
      S_WR: if (rise) begin
        sr_n = sh;
        wd_n = {wr_data[14:0], mdio_out};
        cnt_n = bit_cnt + 5'd1;
        if (bit_cnt == BIT_LAST) begin
          wr_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      // bit 31 still shows data bit 0; the following rise in IDLE clears it
      S_RD: if (rise) begin
        sr_n = sh;
        cnt_n = bit_cnt + 5'd1;
        osr_n = bit_cnt == BIT_DATA ? out_sr : {out_sr[14:0], 1'b0};
        state_n = bit_cnt == BIT_LAST ? S_IDLE : S_RD;
      end
      S_DISC: if (rise && !mdio_oe) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      hdr_sr <= '0;
      wr_data <= '0;
      out_sr <= '0;
      addr <= '0;
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      frame_err <= 1'b0;
      ld <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
      hdr_sr <= sr_n;
      wr_data <= wd_n;
      out_sr <= osr_n;
      addr <= addr_n;
      wr_stb <= wr_n;
      rd_stb <= rd_n;
      frame_err <= err_n;
      ld <= rd_stb;
    end
  end
endmodule

// File: tb/tb_receptor_mdio.sv
// tb_receptor_mdio: directed and random MDIO frames checked against a field-level frame model
module tb_receptor_mdio;
  logic clk = 1'b0;
  logic reset, mdc, mdio_out, mdio_oe, mdio_in, wr_stb, rd_stb, frame_err;
  logic [4:0] addr;
  logic [15:0] wr_data, rd_data, rd_got;
  logic [15:0] regfile [32];
  logic [20:0] wr_q [$];
  int checks = 0, errors = 0, n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
  always #5 clk = ~clk;
  assign rd_data = regfile[addr];
  receptor_mdio #(.PHY_ADDR(5'd1)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .mdio_in(mdio_in), .wr_stb(wr_stb), .rd_stb(rd_stb), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_q.push_back({addr, wr_data});
      n_wr++;
    end
    if (rd_stb) n_rd++;
    if (frame_err) n_err++;
    if (wr_stb && rd_stb) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                                     input logic [4:0] rg, input logic [15:0] d);
    return {st, op, phy, rg, 2'b10, d};
  endfunction
  // 0 = ignored, 1 = write, 2 = read, 3 = frame error
  function automatic int model(input logic [31:0] f);
    if (f[31:30] != 2'b01) return 3;
`ifdef MDIO_PHYAD_CHECK_EN
    if (f[27:23] != 5'd1) return 0;
`endif
    if (f[29:28] == 2'b01) return 1;
    if (f[29:28] == 2'b10) return 2;
    return 3;
  endfunction
  task automatic send(input logic [31:0] f, input int nbits, input int n_oe, input int kind);
    for (int k = 0; k < nbits; k++) begin
      mdio_out = f[31-k];
      mdio_oe = k < n_oe;
      repeat (4) @(posedge clk);
      #1 mdc = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (k == 15) chk("rd_stb_timing", {31'b0, rd_stb}, {31'b0, kind == 2});
      if (k == 31) chk("wr_stb_timing", {31'b0, wr_stb}, {31'b0, kind == 1});
      if (k >= 16) rd_got[31-k] = mdio_in;
      repeat (3) @(posedge clk);
      #1 mdc = 1'b0;
    end
  endtask
  task automatic idle();
    send(32'h0, 1, 0, 0);
  endtask
  task automatic frame(input string tag, input logic [31:0] f);
    int kind, w0, r0, e0, exp_cnt;
    logic [4:0] rg;
    kind = model(f);
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    rg = f[22:18];
    send(f, 32, f[29:28] == 2'b10 ? 16 : 32, kind);
    idle();
    exp_cnt = kind == 1 ? 256 : kind == 2 ? 16 : kind == 3 ? 1 : 0;
    chk({tag, "_strobes"}, (n_wr - w0) * 256 + (n_rd - r0) * 16 + (n_err - e0), exp_cnt);
    if (kind == 1) chk({tag, "_wr"}, {11'b0, wr_q[$]}, {11'b0, rg, f[15:0]});
    if (kind == 2) begin
      chk({tag, "_rd_data"}, {16'b0, rd_got}, {16'b0, regfile[rg]});
      chk({tag, "_rd_addr"}, {27'b0, addr}, {27'b0, rg});
      chk({tag, "_mdio_in_end"}, {31'b0, mdio_in}, 32'b0);
    end
  endtask
  initial begin
    logic [31:0] fa, fb;
    int w0;
    reset = 1'b1;
    mdc = 1'b0;
    mdio_out = 1'b0;
    mdio_oe = 1'b0;
    for (int i = 0; i < 32; i++) regfile[i] = 16'($urandom);
    regfile[3] = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {7'b0, wr_stb, rd_stb, frame_err, mdio_in, addr, wr_data}, 32'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame("wr_5f8a", 32'h5F8A_1234);
    frame("wr_0a", mk(2'b01, 2'b01, 5'd1, 5'h0A, 16'h1234));
    frame("rd_03", mk(2'b01, 2'b10, 5'd1, 5'h03, 16'h0));
    chk("rd_beef", {16'b0, rd_got}, 32'h0000_BEEF);
    frame("st_err", mk(2'b00, 2'b01, 5'd1, 5'h05, 16'hA5A5));
    frame("after_st", mk(2'b01, 2'b01, 5'd1, 5'h05, 16'h5A5A));
    frame("phy2", mk(2'b01, 2'b10, 5'd2, 5'h07, 16'h0));
    frame("phy1", mk(2'b01, 2'b10, 5'd1, 5'h07, 16'h0));
    frame("op_err", mk(2'b01, 2'b11, 5'd1, 5'h04, 16'hFFFF));
    w0 = n_wr;
    send(mk(2'b01, 2'b01, 5'd1, 5'h09, 16'hC0DE), 20, 32, 1);
    reset = 1'b1;
    mdio_oe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outs", {7'b0, wr_stb, rd_stb, frame_err, mdio_in, addr, wr_data}, 32'b0);
    chk("midrst_nostb", n_wr - w0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    frame("post_rst", mk(2'b01, 2'b01, 5'd1, 5'h09, 16'hC0DE));
    fa = mk(2'b01, 2'b01, 5'd1, 5'h11, 16'h1357);
    fb = mk(2'b01, 2'b01, 5'd1, 5'h12, 16'h2468);
    w0 = n_wr;
    send(fa, 32, 32, 1);
    send(fb, 32, 32, 1);
    idle();
    chk("b2b_count", n_wr - w0, 2);
    chk("b2b_first", {11'b0, wr_q[$-1]}, {11'b0, 5'h11, 16'h1357});
    chk("b2b_second", {11'b0, wr_q[$]}, {11'b0, 5'h12, 16'h2468});
    repeat (24) begin
      logic [1:0] st;
      st = $urandom_range(0, 4) == 0 ? 2'($urandom) : 2'b01;
      frame("rand", mk(st, 2'($urandom), 5'($urandom_range(1, 2)), 5'($urandom), 16'($urandom)));
    end
    chk("no_dual_strobe", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
